d_ff: RTL and testbench



---
 rtl/d_ff_pkg.sv | 13 +
 rtl/d_ff_stage.sv | 22 ++
 rtl/d_ff.sv | 67 ++++++
 tb/tb_d_ff.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// Shared constants and types for the d_ff delay register family.
// Optional edge detection in d_ff is enabled with D_FF_EDGE_DETECT_EN.
package d_ff_pkg;

  localparam int unsigned D_FF_MAX_DEPTH = 16;
  localparam int unsigned D_FF_MAX_WIDTH = 64;

  // Bit replicated across WIDTH to form the default reset value.
  localparam logic D_FF_RESET_BIT = 1'b0;

  typedef logic [D_FF_MAX_WIDTH-1:0] d_ff_data_t;

endpackage

// File: rtl/d_ff_stage.sv
// Single WIDTH-bit register with asynchronous active-high reset to RESET_VALUE.
module d_ff_stage
  import d_ff_pkg::*;
#(
  parameter int unsigned     WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{D_FF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_ff.sv
// DEPTH-stage D register chain; dout comes straight from the last stage flop.
// Define D_FF_EDGE_DETECT_EN to add registered rise/fall pulse outputs.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{D_FF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] dout
`ifdef D_FF_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  if (WIDTH == 0 || DEPTH == 0 || DEPTH > D_FF_MAX_DEPTH) begin : g_bad_param
    $error("d_ff: illegal WIDTH=%0d / DEPTH=%0d", WIDTH, DEPTH);
  end

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_d[i] = cin;
    end else begin : g_link
      assign stage_d[i] = stage_q[i-1];
    end

    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .d     (stage_d[i]),
      .q     (stage_q[i])
    );
  end

  assign dout = stage_q[DEPTH-1];

`ifdef D_FF_EDGE_DETECT_EN
  logic [WIDTH-1:0] prev_q;

  // prev_q resets to the same value as dout, so the first edge after release sees no change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= RESET_VALUE;
      rise   <= '0;
      fall   <= '0;
    end else begin
      prev_q <= dout;
      rise   <= dout & ~prev_q;
      fall   <= ~dout & prev_q;
    end
  end
`else
  // Core register chain only; no edge outputs in this build.
`endif

endmodule

// File: tb/tb_d_ff.sv
// Directed self-checking bench for d_ff: a 1x1 instance and an 8-bit, 3-deep instance.
// Edge-detect checks are compiled in when D_FF_EDGE_DETECT_EN is defined.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       cin_a;
  logic       dout_a;
  logic       reset_b;
  logic [7:0] cin_b;
  logic [7:0] dout_b;
`ifdef D_FF_EDGE_DETECT_EN
  logic       rise_a, fall_a;
  logic [7:0] rise_b, fall_b;
`endif

  int total = 0;
  int bad   = 0;

  always #100 clk = ~clk;

  d_ff #(
    .WIDTH       (1),
    .DEPTH       (1),
    .RESET_VALUE (1'b0)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset_a),
    .cin   (cin_a),
    .dout  (dout_a)
`ifdef D_FF_EDGE_DETECT_EN
    ,
    .rise  (rise_a),
    .fall  (fall_a)
`endif
  );

  d_ff #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset_b),
    .cin   (cin_b),
    .dout  (dout_b)
`ifdef D_FF_EDGE_DETECT_EN
    ,
    .rise  (rise_b),
    .fall  (fall_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1;
    cin_a   = 1'b0;
    reset_b = 1'b1;
    cin_b   = 8'h00;

    // Power-up reset, then cin toggling while reset held.
    tick();
    check_eq("a_reset", {7'd0, dout_a}, 8'h00);
    check_eq("b_reset", dout_b, 8'hA5);
    cin_a = 1'b1;
    cin_b = 8'hFF;
    tick();
    tick();
    check_eq("a_reset_hold", {7'd0, dout_a}, 8'h00);
    check_eq("b_reset_hold", dout_b, 8'hA5);

    // Release and capture on DEPTH=1.
    @(negedge clk);
    reset_a = 1'b0;
    tick();
    check_eq("a_capture_1", {7'd0, dout_a}, 8'h01);
    @(negedge clk);
    cin_a = 1'b0;
    tick();
    check_eq("a_capture_0", {7'd0, dout_a}, 8'h00);

    // One-cycle pulse on cin.
    @(negedge clk);
    cin_a = 1'b1;
    tick();
    check_eq("a_pulse_hi", {7'd0, dout_a}, 8'h01);
    @(negedge clk);
    cin_a = 1'b0;
    tick();
    check_eq("a_pulse_lo", {7'd0, dout_a}, 8'h00);

    // Glitch between edges must not be captured.
    @(negedge clk);
    #20 cin_a = 1'b1;
    #20 cin_a = 1'b0;
    tick();
    check_eq("a_glitch", {7'd0, dout_a}, 8'h00);

    // Async reset assertion mid-cycle.
    @(negedge clk);
    cin_a = 1'b1;
    tick();
    check_eq("a_pre_async", {7'd0, dout_a}, 8'h01);
    #30 reset_a = 1'b1;
    #1;
    check_eq("a_async_assert", {7'd0, dout_a}, 8'h00);
    tick();
    check_eq("a_async_hold", {7'd0, dout_a}, 8'h00);
    @(negedge clk);
    reset_a = 1'b0;
    tick();
    check_eq("a_rerelease", {7'd0, dout_a}, 8'h01);

    // DEPTH=3 stream: value at edge N appears after edge N+2.
    @(negedge clk);
    reset_b = 1'b0;
    cin_b   = 8'h11;
    tick();
    check_eq("b_stream_e1", dout_b, 8'hA5);
    @(negedge clk);
    cin_b = 8'h22;
    tick();
    check_eq("b_stream_e2", dout_b, 8'hA5);
    @(negedge clk);
    cin_b = 8'h33;
    tick();
    check_eq("b_stream_11", dout_b, 8'h11);
    @(negedge clk);
    cin_b = 8'h44;
    tick();
    check_eq("b_stream_22", dout_b, 8'h22);
    @(negedge clk);
    cin_b = 8'h55;
    tick();
    check_eq("b_stream_33", dout_b, 8'h33);

    // Mid-stream reset clears every stage.
    #20 reset_b = 1'b1;
    #1;
    check_eq("b_mid_reset", dout_b, 8'hA5);
    @(negedge clk);
    reset_b = 1'b0;
    cin_b   = 8'h66;
    tick();
    check_eq("b_flush_1", dout_b, 8'hA5);
    tick();
    check_eq("b_flush_2", dout_b, 8'hA5);
    tick();
    check_eq("b_after_flush", dout_b, 8'h66);

`ifdef D_FF_EDGE_DETECT_EN
    // dout 0->1->0 gives one rise pulse then one fall pulse, each one edge late.
    @(negedge clk);
    reset_a = 1'b1;
    cin_a   = 1'b0;
    #1;
    check_eq("e_rise_reset", {7'd0, rise_a}, 8'h00);
    check_eq("e_fall_reset", {7'd0, fall_a}, 8'h00);
    @(negedge clk);
    reset_a = 1'b0;
    tick();
    check_eq("e_rise_first", {7'd0, rise_a}, 8'h00);
    check_eq("e_fall_first", {7'd0, fall_a}, 8'h00);
    @(negedge clk);
    cin_a = 1'b1;
    tick();
    check_eq("e_dout_up", {7'd0, dout_a}, 8'h01);
    check_eq("e_rise_early", {7'd0, rise_a}, 8'h00);
    @(negedge clk);
    cin_a = 1'b0;
    tick();
    check_eq("e_rise_pulse", {7'd0, rise_a}, 8'h01);
    check_eq("e_fall_idle", {7'd0, fall_a}, 8'h00);
    tick();
    check_eq("e_rise_end", {7'd0, rise_a}, 8'h00);
    check_eq("e_fall_pulse", {7'd0, fall_a}, 8'h01);
    tick();
    check_eq("e_fall_end", {7'd0, fall_a}, 8'h00);
    check_eq("e_b_rise_quiet", rise_b, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
